imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sits directly upstream of the pipelined core, ahead of the fetch stage's instruction memory.
- Receives a byte stream from a host link (UART/debug bridge) over a valid/ready handshake.
- Assembles little-endian 32-bit words, writes them into instruction memory from word address 0, and verifies an XOR checksum.
- Holds the core in reset until a complete, valid image is loaded, then releases it.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; capacity DEPTH = 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 65536, idle cycles allowed between accepted bytes once a load has started.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_valid  input  1  host byte valid.
- rx_data  input  8  host byte.
- rx_ready  output  1  loader can accept a byte.
- reload  input  1  single-cycle pulse requesting a new load.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  instruction memory word address.
- imem_wdata  output  32  word to write.
- cpu_hold  output  1  1 = core held in reset; top level drives the core reset from this.
- done  output  1  image loaded and verified; core running.
- error  output  1  load failed.
- error_code  output  2  0 none, 1 count overflow, 2 timeout, 3 checksum mismatch.
- words_loaded  output  ADDR_WIDTH+1  words written in the current load.

Behaviour:
- Reset (asynchronous, active-low):
  - state=HDR; cpu_hold=1; every other output 0, including rx_ready.
  - Byte counter, word counter, checksum and timeout counter cleared.
- Handshake:
  - A byte is accepted when rx_valid&rx_ready at a rising edge.
  - rx_ready is registered: 1 in HDR, LOAD and CHECK from the first clock after reset deasserts; 0 in RUN and ERROR.
  - The host must hold rx_data stable while rx_valid=1 and rx_ready=0.
- Frame format: 4-byte little-endian word count N, then N words (4 bytes each, little-endian), then 1 checksum byte = XOR of all payload bytes. Header bytes are excluded from the checksum.
- States:
  - HDR: collect 4 count bytes.
    - After the 4th: N>DEPTH -> ERROR code 1, with no imem writes.
    - N=0 -> CHECK.
    - Otherwise -> LOAD.
  - LOAD:
    - Shift bytes into the word register (byte 0 -> bits 7:0) and fold each into the checksum.
    - The cycle after the 4th byte of a word: imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word; words_loaded increments in that same cycle.
    - After word N-1 is accepted -> CHECK. Bytes may be accepted back-to-back, including during the imem_we cycle.
  - CHECK: accept 1 byte.
    - Equal to the running XOR -> RUN.
    - Otherwise -> ERROR code 3.
  - RUN:
    - Entered on the cycle after the checksum byte is accepted. In that cycle cpu_hold falls to 0 and done rises to 1.
    - All outputs hold their values.
  - ERROR: cpu_hold=1, error=1, error_code latched; stays until reload.
- Timeout:
  - The counter clears on every accepted byte and counts otherwise.
  - It is active in HDR only after the first header byte has been accepted, and is always active in LOAD and CHECK.
  - When the count reaches TIMEOUT_CYCLES -> ERROR code 2.
  - A byte accepted in the same cycle wins; no timeout is raised.
- reload:
  - In RUN or ERROR: next state HDR; cpu_hold=1; done, error, error_code and words_loaded cleared; byte counter, word counter, checksum and timeout counter cleared.
  - In HDR, LOAD or CHECK: ignored.
- Reset asserted mid-load aborts immediately; already-written imem words are not cleared.
- Counters must be wide enough for N=DEPTH without wrap. words_loaded reaches DEPTH exactly on a full image.

Test Plan:
- Normal load:
  - Bytes 02 00 00 00, 13 00 00 00, 93 00 A0 00, checksum 20.
  - Expect: writes addr0=0x00000013 then addr1=0x00A00093, each a single-cycle imem_we.
  - Expect: done=1, cpu_hold=0, words_loaded=2, rx_ready=0.
- Bad checksum:
  - Same frame with checksum 21.
  - Expect: error=1, error_code=3, cpu_hold=1, done=0; both imem writes still occurred.
- Empty and overflow images:
  - Header 00 00 00 00 plus checksum 00 -> RUN, no imem_we.
  - ADDR_WIDTH=4, header 11 00 00 00 (N=17) -> ERROR code 1, no imem_we, rx_ready=0.
- Timeout and recovery:
  - TIMEOUT_CYCLES=16; stop after byte 2 of word 0.
  - Expect: error_code=2 exactly 16 idle cycles later.
  - Then pulse reload and send the normal frame -> done=1 and both words written.
- Handshake stress:
  - Random rx_valid gaps (each under the timeout) with the normal frame.
  - Expect: identical memory contents and checksum result; no byte lost or duplicated.
  - Also: reload pulsed during LOAD has no effect.
- Reset mid-operation:
  - Assert reset after 5 bytes of the normal frame.
  - Expect: outputs at reset values asynchronously, cpu_hold=1.
  - After deassert, the full normal frame loads correctly from the header.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader_if
//  Purpose  : Host byte stream (valid/ready) and instruction-memory write bus
//             shared between the boot loader and its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    // Environment side: drives the byte stream, observes memory writes
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side: consumes the byte stream, drives memory writes
    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Receives a framed byte image (count, LE words, XOR checksum),
//             writes it to instruction memory from address 0 and releases the
//             core from reset once the image verifies.
//  Revision : 1.0  initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  wire logic             clk,
    input  wire logic             reset,
    imem_boot_loader_if.slave     bus,
    input  wire logic             reload,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [32:0]         DEPTH    = 33'(1) << ADDR_WIDTH;
    localparam int                  TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]          ERR_OVF  = 2'd1;
    localparam logic [1:0]          ERR_TMO  = 2'd2;
    localparam logic [1:0]          ERR_SUM  = 2'd3;
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                state;
    logic [1:0]            byte_cnt;   // byte position inside header / word
    logic [23:0]           shift;      // first three bytes of the current group
    logic [7:0]            csum;       // running XOR of payload bytes
    logic [ADDR_WIDTH:0]   n_words;    // validated word count from the header
    logic [TW-1:0]         tmo_cnt;    // idle cycles since last accepted byte

    logic                  accept;
    logic [31:0]           word_full;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  timer_active;
    logic                  timer_expire;

    assign accept       = bus.rx_valid & bus.rx_ready;
    // Completed little-endian group once the 4th byte arrives
    assign word_full    = {bus.rx_data, shift};
    assign count_next   = words_loaded + ONE;
    // Header timeout only arms after the first header byte
    assign timer_active = ((state == S_HDR) && (byte_cnt != 2'd0)) ||
                          (state == S_LOAD) || (state == S_CHECK);
    assign timer_expire = timer_active && !accept && (tmo_cnt == TMO_LAST);

    // Frame-parsing state machine with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_HDR;
            byte_cnt       <= 2'd0;
            shift          <= 24'd0;
            csum           <= 8'd0;
            n_words        <= '0;
            tmo_cnt        <= '0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            error_code     <= 2'd0;
            words_loaded   <= '0;
        end else begin
            bus.imem_we <= 1'b0;

            if (accept) begin
                tmo_cnt <= '0;
            end else if (timer_active) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (timer_expire) begin
                state        <= S_ERROR;
                error        <= 1'b1;
                error_code   <= ERR_TMO;
                bus.rx_ready <= 1'b0;
                tmo_cnt      <= '0;
            end else begin
                case (state)
                    S_HDR: begin
                        bus.rx_ready <= 1'b1;
                        if (accept) begin
                            shift    <= {bus.rx_data, shift[23:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                n_words <= word_full[ADDR_WIDTH:0];
                                if ({1'b0, word_full} > DEPTH) begin
                                    state        <= S_ERROR;
                                    error        <= 1'b1;
                                    error_code   <= ERR_OVF;
                                    bus.rx_ready <= 1'b0;
                                end else if (word_full == 32'd0) begin
                                    state <= S_CHECK;
                                end else begin
                                    state <= S_LOAD;
                                end
                            end
                        end
                    end

                    S_LOAD: begin
                        bus.rx_ready <= 1'b1;
                        if (accept) begin
                            shift    <= {bus.rx_data, shift[23:8]};
                            csum     <= csum ^ bus.rx_data;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
                                bus.imem_wdata <= word_full;
                                words_loaded   <= count_next;
                                if (count_next == n_words) begin
                                    state <= S_CHECK;
                                end
                            end
                        end
                    end

                    S_CHECK: begin
                        bus.rx_ready <= 1'b1;
                        if (accept) begin
                            bus.rx_ready <= 1'b0;
                            if (bus.rx_data == csum) begin
                                state    <= S_RUN;
                                cpu_hold <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                state      <= S_ERROR;
                                error      <= 1'b1;
                                error_code <= ERR_SUM;
                            end
                        end
                    end

                    S_RUN, S_ERROR: begin
                        bus.rx_ready <= 1'b0;
                        if (reload) begin
                            state        <= S_HDR;
                            bus.rx_ready <= 1'b1;
                            cpu_hold     <= 1'b1;
                            done         <= 1'b0;
                            error        <= 1'b0;
                            error_code   <= 2'd0;
                            words_loaded <= '0;
                            byte_cnt     <= 2'd0;
                            shift        <= 24'd0;
                            csum         <= 8'd0;
                            tmo_cnt      <= '0;
                        end
                    end

                    default: begin
                        state        <= S_HDR;
                        bus.rx_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Purpose  : Self-checking bench for imem_boot_loader: a byte-stream level
//             reference model compared every cycle, plus literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int AW    = 4;
    localparam int TO    = 16;
    localparam int DEPTH = 16;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reload = 1'b0;

    logic          cpu_hold, done, error;
    logic [1:0]    error_code;
    logic [AW:0]   words_loaded;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .reload       (reload),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .error_code   (error_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [31:0] mem      [0:DEPTH-1];
    logic [31:0] exp_full [0:DEPTH-1];
    logic [7:0]  fq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshake events sampled at the active edge for the model
    logic       acc_q = 1'b0;
    logic       pe_ok = 1'b0;
    logic       rl_q  = 1'b0;
    logic [7:0] byte_q = 8'd0;
    always @(posedge clk) begin
        acc_q  <= reset && bus.rx_valid && bus.rx_ready;
        byte_q <= bus.rx_data;
        rl_q   <= reload;
        pe_ok  <= reset;
    end

    // Reference model: position in the byte stream decides everything
    int          m_idx, m_idle, m_code, m_addr, m_wl;
    logic [31:0] m_hdr, m_w, m_data;
    logic [7:0]  m_x;
    bit          m_done, m_err, m_we, m_rdy;

    task automatic model_clear();
        m_idx = 0; m_idle = 0; m_code = 0; m_addr = 0; m_wl = 0;
        m_hdr = 0; m_w = 0; m_data = 0; m_x = 0;
        m_done = 0; m_err = 0; m_we = 0; m_rdy = 1;
    endtask

    task automatic model_step(input logic acc, input logic [7:0] b, input logic rl);
        int k;
        m_we = 0;
        if (m_done || m_err) begin
            if (rl) model_clear();
            else    m_rdy = 0;
            return;
        end
        m_rdy = 1;
        if (acc) begin
            m_idle = 0;
            if (m_idx < 4) begin
                m_hdr = m_hdr | (32'(b) << (8 * m_idx));
                if (m_idx == 3 && longint'(m_hdr) > longint'(DEPTH)) begin
                    m_err = 1; m_code = 1;
                end
            end else if (longint'(m_idx) < 4 + 4 * longint'(m_hdr)) begin
                k   = m_idx - 4;
                m_x = m_x ^ b;
                m_w = m_w | (32'(b) << (8 * (k % 4)));
                if (k % 4 == 3) begin
                    m_we = 1; m_addr = k / 4; m_data = m_w; m_wl = k / 4 + 1; m_w = 0;
                end
            end else begin
                if (b == m_x) m_done = 1;
                else begin m_err = 1; m_code = 3; end
            end
            m_idx++;
        end else if (m_idx > 0) begin
            m_idle++;
            if (m_idle == TO) begin m_err = 1; m_code = 2; end
        end
        if (m_done || m_err) m_rdy = 0;
    endtask

    // Compare process: every negedge, DUT outputs against the model
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset || !pe_ok) begin
                model_clear();
                m_rdy = 0;
            end else begin
                model_step(acc_q, byte_q, rl_q);
            end
            check("rx_ready",     64'(bus.rx_ready),  64'(m_rdy));
            check("cpu_hold",     64'(cpu_hold),      64'(!m_done));
            check("done",         64'(done),          64'(m_done));
            check("error",        64'(error),         64'(m_err));
            check("error_code",   64'(error_code),    64'(m_code));
            check("words_loaded", 64'(words_loaded),  64'(m_wl));
            check("imem_we",      64'(bus.imem_we),   64'(m_we));
            if (m_we) begin
                check("imem_addr",  64'(bus.imem_addr),  64'(m_addr));
                check("imem_wdata", 64'(bus.imem_wdata), 64'(m_data));
            end
            if (bus.imem_we === 1'b1) begin
                wr_cnt++;
                mem[bus.imem_addr] = bus.imem_wdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", 64'(bus.rx_ready), 64'(1));
        if (bus.rx_ready === 1'b1) @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int maxgap, input int reload_at);
        for (int i = 0; i < fq.size(); i++) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            if (i == reload_at) begin
                reload = 1'b1;
                @(negedge clk);
                reload = 1'b0;
            end
            send_byte(fq[i]);
        end
    endtask

    task automatic load_normal(input logic [7:0] cs);
        fq.delete();
        fq.push_back(8'h02); fq.push_back(8'h00); fq.push_back(8'h00); fq.push_back(8'h00);
        fq.push_back(8'h13); fq.push_back(8'h00); fq.push_back(8'h00); fq.push_back(8'h00);
        fq.push_back(8'h93); fq.push_back(8'h00); fq.push_back(8'hA0); fq.push_back(8'h00);
        fq.push_back(cs);
    endtask

    task automatic load_full();
        logic [7:0] x = 8'd0;
        fq.delete();
        fq.push_back(8'(DEPTH)); fq.push_back(8'h00); fq.push_back(8'h00); fq.push_back(8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            exp_full[i] = (32'h0101_0101 * 32'(i)) ^ 32'hC3A5_5A3C;
            for (int j = 0; j < 4; j++) begin
                fq.push_back(exp_full[i][8*j +: 8]);
                x = x ^ exp_full[i][8*j +: 8];
            end
        end
        fq.push_back(x);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cpu_hold", 64'(cpu_hold), 64'(1));
        check("rst_rx_ready", 64'(bus.rx_ready), 64'(0));
        check("rst_done",     64'(done), 64'(0));
        check("rst_imem_we",  64'(bus.imem_we), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Normal image
        w0 = wr_cnt;
        load_normal(8'h20);
        send_frame(0, -1);
        #1;
        check("norm_done",     64'(done), 64'(1));
        check("norm_cpu_hold", 64'(cpu_hold), 64'(0));
        check("norm_words",    64'(words_loaded), 64'(2));
        check("norm_rx_ready", 64'(bus.rx_ready), 64'(0));
        check("norm_mem0",     64'(mem[0]), 64'h0000_0013);
        check("norm_mem1",     64'(mem[1]), 64'h00A0_0093);
        check("norm_writes",   64'(wr_cnt - w0), 64'(2));
        pulse_reload();
        #1;
        check("reload_hold",  64'(cpu_hold), 64'(1));
        check("reload_done",  64'(done), 64'(0));
        check("reload_words", 64'(words_loaded), 64'(0));

        // Bad checksum
        w0 = wr_cnt;
        load_normal(8'h21);
        send_frame(0, -1);
        #1;
        check("bad_error",  64'(error), 64'(1));
        check("bad_code",   64'(error_code), 64'(3));
        check("bad_hold",   64'(cpu_hold), 64'(1));
        check("bad_done",   64'(done), 64'(0));
        check("bad_writes", 64'(wr_cnt - w0), 64'(2));
        pulse_reload();

        // Empty image
        w0 = wr_cnt;
        fq.delete();
        for (int i = 0; i < 5; i++) fq.push_back(8'h00);
        send_frame(0, -1);
        #1;
        check("empty_done",   64'(done), 64'(1));
        check("empty_writes", 64'(wr_cnt - w0), 64'(0));
        pulse_reload();

        // Overflow: N = DEPTH + 1
        w0 = wr_cnt;
        fq.delete();
        fq.push_back(8'h11); fq.push_back(8'h00); fq.push_back(8'h00); fq.push_back(8'h00);
        send_frame(0, -1);
        #1;
        check("ovf_code",     64'(error_code), 64'(1));
        check("ovf_rx_ready", 64'(bus.rx_ready), 64'(0));
        check("ovf_writes",   64'(wr_cnt - w0), 64'(0));
        pulse_reload();

        // Full-capacity image
        load_full();
        send_frame(0, -1);
        #1;
        check("full_done",  64'(done), 64'(1));
        check("full_words", 64'(words_loaded), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) check("full_mem", 64'(mem[i]), 64'(exp_full[i]));
        pulse_reload();

        // Timeout after byte 2 of word 0, then recovery
        load_normal(8'h20);
        for (int i = 0; i < 6; i++) send_byte(fq[i]);
        idle(15);
        #1;
        check("tmo_not_yet", 64'(error), 64'(0));
        @(negedge clk);
        #1;
        check("tmo_error", 64'(error), 64'(1));
        check("tmo_code",  64'(error_code), 64'(2));
        pulse_reload();
        w0 = wr_cnt;
        send_frame(0, -1);
        #1;
        check("rec_done",   64'(done), 64'(1));
        check("rec_writes", 64'(wr_cnt - w0), 64'(2));
        pulse_reload();

        // Random gaps, reload pulsed mid-LOAD
        w0 = wr_cnt;
        mem[0] = 32'hDEAD_BEEF;
        mem[1] = 32'hDEAD_BEEF;
        send_frame(10, 6);
        #1;
        check("stress_done",   64'(done), 64'(1));
        check("stress_mem0",   64'(mem[0]), 64'h0000_0013);
        check("stress_mem1",   64'(mem[1]), 64'h00A0_0093);
        check("stress_writes", 64'(wr_cnt - w0), 64'(2));
        pulse_reload();

        // Reset mid-operation
        for (int i = 0; i < 5; i++) send_byte(fq[i]);
        #2 reset = 1'b0;
        #1;
        check("arst_rx_ready", 64'(bus.rx_ready), 64'(0));
        check("arst_cpu_hold", 64'(cpu_hold), 64'(1));
        check("arst_words",    64'(words_loaded), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        w0 = wr_cnt;
        send_frame(0, -1);
        #1;
        check("post_rst_done",   64'(done), 64'(1));
        check("post_rst_writes", 64'(wr_cnt - w0), 64'(2));
        check("post_rst_mem1",   64'(mem[1]), 64'h00A0_0093);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
